// File: rtl/counter_event_log.sv
// -----------------------------------------------------------------------------
// counter_event_log
//   Timestamped event logger that sits downstream of counter #1. It watches
//   the count==00 and count==80 flags. When a flag event occurs, it writes
//   {event code, count, timestamp} into a show-ahead FIFO. The host drains
//   the FIFO with a one-cycle pop strobe.
//
//   Entry layout:
//     [31:30] code   01 = eq00, 10 = eq80, 11 = both in the same cycle
//     [29:24] zero
//     [23:16] count value in the event cycle
//     [15:0]  timestamp in the event cycle (value before that cycle's tick)
//
// Parameters
//   DEPTH_LOG2   FIFO depth is 2**DEPTH_LOG2 entries (legal range 2..8)
//   EDGE_DETECT  1: log flag rising edges; 0: log every cycle a flag is high
//
// Ports
//   clk1        board clock; all logic runs on posedge
//   reset1      synchronous, active-high reset
//   count       counter #1 value
//   evt_eq00    count==00 flag (level)
//   evt_eq80    count==80 flag (level)
//   evt_tick    one-cycle tick that advances the timestamp
//   enable      1: events may be written to the FIFO
//   pop         one-cycle strobe that discards the head entry
//   clear       one-cycle strobe that flushes the FIFO and zeroes ts/overflow
//   rd_data     head entry; 0 when the FIFO is empty
//   rd_valid    FIFO is non-empty
//   level       number of entries held
//   overflow    sticky: an event was dropped while the FIFO was full
//   drop_count  (EVT_LOG_DROPCOUNT_EN only) saturating count of dropped events
//
// Configuration
//   Define EVT_LOG_DROPCOUNT_EN to add the drop_count output.
// -----------------------------------------------------------------------------
module counter_event_log #(
  parameter int DEPTH_LOG2  = 4,
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic                  clk1,
  input  logic                  reset1,
  input  logic [7:0]            count,
  input  logic                  evt_eq00,
  input  logic                  evt_eq80,
  input  logic                  evt_tick,
  input  logic                  enable,
  input  logic                  pop,
  input  logic                  clear,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
`ifdef EVT_LOG_DROPCOUNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  localparam int                 DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [15:0]           ts;
  logic                  prev_eq00;
  logic                  prev_eq80;

  logic                  hit00;
  logic                  hit80;
  logic                  is_event;
  logic                  is_full;
  logic                  is_empty;
  logic                  do_pop;
  logic                  accept;
  logic                  do_write;
  logic                  do_drop;
  logic [31:0]           entry;

  assign hit00    = EDGE_DETECT ? (evt_eq00 & ~prev_eq00) : evt_eq00;
  assign hit80    = EDGE_DETECT ? (evt_eq80 & ~prev_eq80) : evt_eq80;
  assign is_event = hit00 | hit80;
  assign is_full  = (level == FULL_LEVEL);
  assign is_empty = (level == '0);

  // A pop on an empty FIFO is ignored. That way, an event written in the same
  // cycle is not popped before it becomes visible.
  assign do_pop   = pop & ~is_empty;
  assign accept   = is_event & enable;
  // When the FIFO is full, a pop in the same cycle frees the slot the write needs.
  assign do_write = accept & (~is_full | do_pop);
  assign do_drop  = accept & is_full & ~do_pop;
  assign entry    = {hit80, hit00, 6'b0, count, ts};

  assign rd_valid = ~is_empty;
  assign rd_data  = rd_valid ? mem[rd_ptr] : 32'h0;

  // NOTE: state registers use non-blocking assignments only. All flops then
  // sample pre-edge values, so there are no ordering races between blocks.
  always_ff @(posedge clk1) begin
    if (reset1) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ts        <= '0;
      overflow  <= 1'b0;
      // If a flag is already high when reset releases, it must not be logged.
      prev_eq00 <= 1'b1;
      prev_eq80 <= 1'b1;
    end else begin
      // The edge history follows the inputs even during clear and while
      // logging is disabled.
      prev_eq00 <= evt_eq00;
      prev_eq80 <= evt_eq80;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        ts       <= '0;
        overflow <= 1'b0;
      end else begin
        if (evt_tick) ts     <= ts + 16'd1;
        if (do_write) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (do_pop)   rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        case ({do_write, do_pop})
          2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
          2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
          default: level <= level;
        endcase
        if (do_drop) overflow <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset. Pointers and level decide what is
  // valid, and rd_data is forced to zero while the FIFO is empty.
  always_ff @(posedge clk1) begin
    if (!reset1 && !clear && do_write) mem[wr_ptr] <= entry;
  end

`ifdef EVT_LOG_DROPCOUNT_EN
  // If both flags are dropped in one cycle, that counts as a single drop.
  always_ff @(posedge clk1) begin
    if (reset1 || clear) begin
      drop_count <= 8'h00;
    end else if (do_drop && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_event_log.sv
// -----------------------------------------------------------------------------
// tb_counter_event_log
//   Self-checking bench for counter_event_log with the default parameters
//   (16-entry FIFO, edge detection on). A queue-based reference model runs
//   alongside the DUT. The DUT outputs are compared with the model on every
//   falling edge. Directed scenarios add literal expectations, and a
//   randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_counter_event_log;

  localparam int DEPTH = 16;

  logic        clk1 = 1'b0;
  logic        reset1;
  logic [7:0]  count;
  logic        evt_eq00, evt_eq80, evt_tick, enable, pop, clear;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  level;
  logic        overflow;
`ifdef EVT_LOG_DROPCOUNT_EN
  logic [7:0]  drop_count;
`endif

  int errors = 0;
  int checks = 0;

  counter_event_log #(.DEPTH_LOG2(4), .EDGE_DETECT(1'b1)) dut (
    .clk1     (clk1),
    .reset1   (reset1),
    .count    (count),
    .evt_eq00 (evt_eq00),
    .evt_eq80 (evt_eq80),
    .evt_tick (evt_tick),
    .enable   (enable),
    .pop      (pop),
    .clear    (clear),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .level    (level),
    .overflow (overflow)
`ifdef EVT_LOG_DROPCOUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] q[$];
  int unsigned m_ts    = 0;
  logic        m_prev00 = 1'b1;
  logic        m_prev80 = 1'b1;
  logic        m_ovf   = 1'b0;
  int          m_drop  = 0;
  logic        h00, h80;

  always @(posedge clk1) begin
    h00 = evt_eq00 && !m_prev00;
    h80 = evt_eq80 && !m_prev80;
    if (reset1) begin
      q.delete();
      m_ts = 0; m_ovf = 1'b0; m_drop = 0;
      m_prev00 = 1'b1; m_prev80 = 1'b1;
    end else begin
      if (clear) begin
        q.delete();
        m_ts = 0; m_ovf = 1'b0; m_drop = 0;
      end else begin
        if (pop && q.size() > 0) void'(q.pop_front());
        if ((h00 || h80) && enable) begin
          if (q.size() < DEPTH) q.push_back({h80, h00, 6'b0, count, m_ts[15:0]});
          else begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
          end
        end
        if (evt_tick) m_ts = (m_ts + 1) % 65536;
      end
      m_prev00 = evt_eq00;
      m_prev80 = evt_eq80;
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge clk1) begin
    check("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    check("rd_data", rd_data, (q.size() != 0) ? q[0] : 32'h0);
    check("level", 32'(level), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef EVT_LOG_DROPCOUNT_EN
    check("drop_count", 32'(drop_count), 32'(m_drop));
`endif
  end

  task automatic step();
    @(negedge clk1);
  endtask

  task automatic idle_inputs();
    evt_eq00 = 1'b0; evt_eq80 = 1'b0; evt_tick = 1'b0;
    pop = 1'b0; clear = 1'b0; count = 8'h00;
  endtask

  // Make one eq80 rising edge with the given count, then drop the flag again.
  task automatic eq80_event(input logic [7:0] c);
    evt_eq80 = 1'b1; count = c; step();
    evt_eq80 = 1'b0; step();
  endtask

  initial begin
    reset1 = 1'b1; enable = 1'b1;
    idle_inputs();
    // ---- 1: a flag held high through reset is not logged ----
    evt_eq00 = 1'b1;
    step(); step();
    reset1 = 1'b0;
    step();
    check("t1_no_entry_level", 32'(level), 32'd0);
    check("t1_no_entry_valid", 32'(rd_valid), 32'd0);
    evt_eq00 = 1'b0; evt_tick = 1'b1;
    repeat (3) step();
    evt_tick = 1'b0; evt_eq00 = 1'b1; count = 8'h00;
    step();
    check("t1_rd_data", rd_data, 32'h4000_0003);
    check("t1_level", 32'(level), 32'd1);

    // ---- 2: both flags rise in the same cycle ----
    evt_eq00 = 1'b0; clear = 1'b1; step();
    clear = 1'b0; evt_tick = 1'b1;
    repeat (16) step();
    evt_tick = 1'b0; evt_eq00 = 1'b1; evt_eq80 = 1'b1; count = 8'h80;
    step();
    check("t2_rd_data", rd_data, 32'hC080_0010);
    idle_inputs();

    // ---- 3: 17 events into a 16-entry FIFO, then drain it ----
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 17; i++) eq80_event(8'(i));
    check("t3_level_full", 32'(level), 32'd16);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_head_first", rd_data, 32'h8000_0000);
`ifdef EVT_LOG_DROPCOUNT_EN
    check("t3_drop_count", 32'(drop_count), 32'd1);
`endif
    pop = 1'b1;
    repeat (15) step();
    pop = 1'b0;
    check("t3_head_16th", rd_data, 32'h800F_0000);
    pop = 1'b1; step(); pop = 1'b0;
    check("t3_drained_valid", 32'(rd_valid), 32'd0);
    check("t3_drained_data", rd_data, 32'h0);
    pop = 1'b1; step(); pop = 1'b0;                 // pop while empty is ignored
    check("t3_empty_pop_level", 32'(level), 32'd0);

    // ---- 4: FIFO full, event and pop in the same cycle ----
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 16; i++) eq80_event(8'(i + 8'h20));
    evt_eq80 = 1'b1; count = 8'hAA; pop = 1'b1; step();
    evt_eq80 = 1'b0; pop = 1'b0;
    check("t4_level", 32'(level), 32'd16);
    check("t4_overflow", 32'(overflow), 32'd0);
    pop = 1'b1;
    repeat (15) step();
    pop = 1'b0;
    check("t4_newest_at_tail", rd_data, 32'h80AA_0000);
    // The FIFO is empty when this cycle starts. The pop is ignored and the event is written.
    pop = 1'b1; step();
    pop = 1'b1; evt_eq80 = 1'b1; count = 8'h55; step();
    pop = 1'b0; evt_eq80 = 1'b0;
    check("t4_empty_evt_pop", rd_data, 32'h8055_0000);
    check("t4_empty_evt_pop_lvl", 32'(level), 32'd1);

    // ---- 6: clear with an event in the same cycle, then logging disabled ----
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 5; i++) eq80_event(8'(i));
    clear = 1'b1; evt_eq80 = 1'b1; evt_tick = 1'b1; step();
    clear = 1'b0; evt_eq80 = 1'b0; evt_tick = 1'b0;
    check("t6_level", 32'(level), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    step();
    evt_eq00 = 1'b1; count = 8'h12; step();
    check("t6_ts_zeroed", rd_data, 32'h4012_0000);
    evt_eq00 = 1'b0; step();
    enable = 1'b0;
    evt_eq00 = 1'b1; evt_eq80 = 1'b1; step();
    evt_eq00 = 1'b0; evt_eq80 = 1'b0; step();
    evt_eq80 = 1'b1; step();
    check("t6_disabled_level", 32'(level), 32'd1);
    enable = 1'b1; evt_eq80 = 1'b0;

    // ---- a reset in the middle of operation discards everything ----
    reset1 = 1'b1; step(); reset1 = 1'b0;
    check("rst_mid_level", 32'(level), 32'd0);
    check("rst_mid_data", rd_data, 32'h0);

    // ---- 5: timestamp wrap ----
    clear = 1'b1; step(); clear = 1'b0;
    evt_tick = 1'b1;
    repeat (65534) step();
    evt_eq00 = 1'b1; count = 8'h00; step();          // logs FFFE; ts becomes FFFF
    evt_eq00 = 1'b0; step();                          // ts wraps to 0000
    evt_tick = 1'b0; evt_eq00 = 1'b1; step();         // logs 0000
    evt_eq00 = 1'b0;
    check("t5_ts_fffe", rd_data, 32'h4000_FFFE);
    pop = 1'b1; step(); pop = 1'b0;
    check("t5_ts_wrapped", rd_data, 32'h4000_0000);

    // ---- randomized phase, checked against the model ----
    for (int n = 0; n < 4000; n++) begin
      evt_eq00 = ($urandom_range(3) == 0);
      evt_eq80 = ($urandom_range(3) == 0);
      evt_tick = $urandom_range(1);
      count    = 8'($urandom);
      enable   = ($urandom_range(7) != 0);
      pop      = (n < 2000) ? ($urandom_range(7) == 0) : ($urandom_range(1) == 1);
      clear    = ($urandom_range(149) == 0);
      reset1   = ($urandom_range(499) == 0);
      step();
    end
    reset1 = 1'b0;
    idle_inputs();
    step();

    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
